// File: rtl/mips_tb_pkg.sv
// Shared types and constants for the MIPS program loader / result checker.
package mips_tb_pkg;

   localparam int XLEN_DEF = 32;
   localparam int REG_AW   = 5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_RUN     = 3'd2,
      ST_CHK_REQ = 3'd3,
      ST_CHK_CMP = 3'd4,
      ST_DONE    = 3'd5
   } seq_state_t;

endpackage

// File: rtl/run_monitor.sv
// Watches the core while it runs: counts cycles, detects a PC that has stopped
// moving (jump-to-self) and flags the cycle limit. Halt has priority over timeout.
module run_monitor #(
   parameter int XLEN           = 32,
   parameter int RUN_W          = 16,
   parameter int MAX_RUN_CYCLES = 256,
   parameter int STALL_CYCLES   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             run_en,
   input  logic [XLEN-1:0]  core_pc,
   output logic [RUN_W-1:0] cycles,
   output logic             halt,
   output logic             timeout_hit
);

   localparam int STALL_W = $clog2(STALL_CYCLES) + 1;
   localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(STALL_CYCLES - 1);
   localparam logic [RUN_W-1:0]   CYCLE_LIMIT = RUN_W'(MAX_RUN_CYCLES);

   logic [RUN_W-1:0]   cycles_q, cycles_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic [XLEN-1:0]    pc_prev_q, pc_prev_d;
   logic               pc_valid_q, pc_valid_d;
   logic               pc_same;

   // Next-state for counters plus the combinational halt/timeout decision.
   // pc_valid keeps the first RUN cycle from comparing against a stale PC.
   always_comb begin
      cycles_d    = cycles_q;
      stall_d     = stall_q;
      pc_prev_d   = pc_prev_q;
      pc_valid_d  = pc_valid_q;
      pc_same     = 1'b0;
      halt        = 1'b0;
      timeout_hit = 1'b0;
      if (clear) begin
         cycles_d   = '0;
         stall_d    = '0;
         pc_valid_d = 1'b0;
      end else if (run_en) begin
         pc_same     = pc_valid_q && (core_pc == pc_prev_q);
         stall_d     = pc_same ? stall_q + 1'b1 : '0;
         cycles_d    = cycles_q + 1'b1;
         pc_prev_d   = core_pc;
         pc_valid_d  = 1'b1;
         halt        = pc_same && (stall_d == STALL_LIMIT);
         timeout_hit = !halt && (cycles_d == CYCLE_LIMIT);
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycles_q   <= '0;
         stall_q    <= '0;
         pc_prev_q  <= '0;
         pc_valid_q <= 1'b0;
      end else begin
         cycles_q   <= cycles_d;
         stall_q    <= stall_d;
         pc_prev_q  <= pc_prev_d;
         pc_valid_q <= pc_valid_d;
      end
   end

   assign cycles = cycles_q;

endmodule

// File: rtl/mips_test_sequencer.sv
// Program loader and result checker wrapped around the single-cycle MIPS core.
//
// state   | meaning
// IDLE    | core held in reset, waiting for start
// LOAD    | streaming program words into instruction memory
// RUN     | core released and clocked until halt or cycle limit
// CHK_REQ | core frozen, waiting for the next expected register value
// CHK_CMP | comparing register-file read data against the latched value
// DONE    | results valid, waiting for the next start
module mips_test_sequencer
   import mips_tb_pkg::*;
#(
   parameter int XLEN           = XLEN_DEF,
   parameter int IMEM_AW        = 8,
   parameter int RUN_W          = 16,
   parameter int MAX_RUN_CYCLES = 256,
   parameter int STALL_CYCLES   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [IMEM_AW:0]  prog_len,
   input  logic              prog_valid,
   output logic              prog_ready,
   input  logic [XLEN-1:0]   prog_data,
   output logic              imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [XLEN-1:0]   imem_wdata,
   output logic              core_rst,
   output logic              core_en,
   input  logic [XLEN-1:0]   core_pc,
   output logic [REG_AW-1:0] rf_raddr,
   input  logic [XLEN-1:0]   rf_rdata,
   input  logic              chk_valid,
   output logic              chk_ready,
   input  logic [REG_AW-1:0] chk_reg,
   input  logic [XLEN-1:0]   chk_value,
   input  logic              chk_last,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [7:0]        fail_count,
   output logic [REG_AW-1:0] first_fail_reg,
   output logic [RUN_W-1:0]  cycles
);

   seq_state_t state_q, state_d;
   logic [IMEM_AW-1:0] wr_addr_q, wr_addr_d;
   logic [IMEM_AW:0]   remain_q, remain_d;
   logic               imem_we_q, imem_we_d;
   logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
   logic [XLEN-1:0]    imem_wdata_q, imem_wdata_d;
   logic [XLEN-1:0]    chk_val_q, chk_val_d;
   logic               chk_last_q, chk_last_d;
   logic [REG_AW-1:0]  rf_raddr_q, rf_raddr_d;
   logic [7:0]         fail_count_q, fail_count_d;
   logic [REG_AW-1:0]  first_fail_q, first_fail_d;
   logic               timeout_q, timeout_d;
   logic               start_ok, mon_halt, mon_timeout;

   assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   run_monitor #(
      .XLEN           (XLEN),
      .RUN_W          (RUN_W),
      .MAX_RUN_CYCLES (MAX_RUN_CYCLES),
      .STALL_CYCLES   (STALL_CYCLES)
   ) u_run_monitor (
      .clk         (clk),
      .rst         (rst),
      .clear       (start_ok),
      .run_en      (state_q == ST_RUN),
      .core_pc     (core_pc),
      .cycles      (cycles),
      .halt        (mon_halt),
      .timeout_hit (mon_timeout)
   );

   // Next-state logic: load stream, run exit, check handshake and compare.
   always_comb begin
      state_d      = state_q;
      wr_addr_d    = wr_addr_q;
      remain_d     = remain_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      chk_val_d    = chk_val_q;
      chk_last_d   = chk_last_q;
      rf_raddr_d   = rf_raddr_q;
      fail_count_d = fail_count_q;
      first_fail_d = first_fail_q;
      timeout_d    = timeout_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               fail_count_d = '0;
               first_fail_d = '0;
               timeout_d    = 1'b0;
               wr_addr_d    = '0;
               remain_d     = prog_len;
               state_d      = (prog_len == '0) ? ST_RUN : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (prog_valid) begin
               imem_we_d    = 1'b1;
               imem_addr_d  = wr_addr_q;
               imem_wdata_d = prog_data;
               wr_addr_d    = wr_addr_q + 1'b1;
               remain_d     = remain_q - 1'b1;
               if (remain_q == {{IMEM_AW{1'b0}}, 1'b1}) state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (mon_halt) begin
               state_d = ST_CHK_REQ;
            end else if (mon_timeout) begin
               timeout_d = 1'b1;
               state_d   = ST_CHK_REQ;
            end
         end
         ST_CHK_REQ: begin
            if (chk_valid) begin
               chk_val_d  = chk_value;
               chk_last_d = chk_last;
               rf_raddr_d = chk_reg;
               state_d    = ST_CHK_CMP;
            end
         end
         ST_CHK_CMP: begin
            if (rf_rdata != chk_val_q) begin
               if (fail_count_q != 8'hFF) fail_count_d = fail_count_q + 1'b1;
               if (fail_count_q == 8'h00) first_fail_d = rf_raddr_q;
            end
            state_d = chk_last_q ? ST_DONE : ST_CHK_REQ;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         wr_addr_q    <= '0;
         remain_q     <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         chk_val_q    <= '0;
         chk_last_q   <= 1'b0;
         rf_raddr_q   <= '0;
         fail_count_q <= '0;
         first_fail_q <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_addr_q    <= wr_addr_d;
         remain_q     <= remain_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         chk_val_q    <= chk_val_d;
         chk_last_q   <= chk_last_d;
         rf_raddr_q   <= rf_raddr_d;
         fail_count_q <= fail_count_d;
         first_fail_q <= first_fail_d;
         timeout_q    <= timeout_d;
      end
   end

   // The core stays out of reset after RUN so debug reads see its final registers.
   assign core_rst       = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   assign core_en        = (state_q == ST_RUN);
   assign prog_ready     = (state_q == ST_LOAD);
   assign chk_ready      = (state_q == ST_CHK_REQ);
   assign busy           = !((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign done           = (state_q == ST_DONE);
   assign pass           = done && (fail_count_q == 8'h00) && !timeout_q;
   assign timeout        = timeout_q;
   assign fail_count     = fail_count_q;
   assign first_fail_reg = first_fail_q;
   assign rf_raddr       = rf_raddr_q;
   assign imem_we        = imem_we_q;
   assign imem_addr      = imem_addr_q;
   assign imem_wdata     = imem_wdata_q;

endmodule

// File: tb/tb_mips_test_sequencer.sv
// Bench for mips_test_sequencer: a tiny behavioural MIPS core and imem sit on
// the DUT's ports; scenario tables plus randomized check streams are scored
// against expectations derived from what each program computes.
module tb_mips_test_sequencer;

   localparam int MAXC  = 20;
   localparam int STALL = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [8:0]  prog_len = '0;
   logic        prog_valid = 1'b0;
   logic        prog_ready;
   logic [31:0] prog_data = '0;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        core_rst, core_en;
   logic [31:0] core_pc;
   logic [4:0]  rf_raddr;
   logic [31:0] rf_rdata;
   logic        chk_valid = 1'b0;
   logic        chk_ready;
   logic [4:0]  chk_reg = '0;
   logic [31:0] chk_value = '0;
   logic        chk_last = 1'b0;
   logic        busy, done, pass, timeout;
   logic [7:0]  fail_count;
   logic [4:0]  first_fail_reg;
   logic [15:0] cycles;

   always #5 clk = ~clk;

   mips_test_sequencer #(
      .XLEN(32), .IMEM_AW(8), .RUN_W(16), .MAX_RUN_CYCLES(MAXC), .STALL_CYCLES(STALL)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
      .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_data(prog_data),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_rst(core_rst), .core_en(core_en), .core_pc(core_pc),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_reg(chk_reg),
      .chk_value(chk_value), .chk_last(chk_last),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .fail_count(fail_count), .first_fail_reg(first_fail_reg), .cycles(cycles)
   );

   // ---------------- behavioural imem + core ----------------
   logic [31:0] imem [256];
   logic [31:0] regs [32];
   logic [31:0] pc;
   logic [7:0]  wr_addr_log [$];
   logic [31:0] wr_data_log [$];

   assign core_pc  = pc;
   assign rf_rdata = regs[rf_raddr];

   always @(posedge clk) begin
      if (imem_we) begin
         imem[imem_addr] <= imem_wdata;
         wr_addr_log.push_back(imem_addr);
         wr_data_log.push_back(imem_wdata);
      end
   end

   always @(posedge clk) begin : core_model
      logic [31:0] ins;
      if (core_rst) begin
         pc <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (core_en) begin
         ins = imem[pc[9:2]];
         pc  <= pc + 32'd4;
         case (ins[31:26])
            6'h00: if (ins[15:11] != 5'd0) begin
               if (ins[5:0] == 6'h20) regs[ins[15:11]] <= regs[ins[25:21]] + regs[ins[20:16]];
               if (ins[5:0] == 6'h22) regs[ins[15:11]] <= regs[ins[25:21]] - regs[ins[20:16]];
            end
            6'h08: if (ins[20:16] != 5'd0)
               regs[ins[20:16]] <= regs[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
            6'h02: pc <= {pc[31:28], ins[25:0], 2'b00};
            default: ;
         endcase
      end
   end

   // ---------------- programs and tables ----------------
   logic [31:0] prog_norm [6];
   logic [31:0] prog_loop [2];

   typedef struct { logic [4:0] r; logic [31:0] v; } cvec_t;
   typedef struct {
      int prog; int bp; bit sil; int cfirst; int cn;
      int exp_fail; int exp_first; bit exp_pass; bit exp_tmo; int exp_cyc;
   } scen_t;
   cvec_t ctab [9];
   scen_t scen [4];

   int checks = 0;
   int errors = 0;
   bit core_en_at_chk;

   // Values the normal program leaves behind: t0=5, t1=10, t2=t0+t1, t3=t1-t0.
   function automatic logic [31:0] ref_val(input int r);
      case (r)
         8:  return 32'd5;
         9:  return 32'd10;
         10: return 32'd15;
         11: return 32'd5;
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic load_prog(input int which, input int bp, input bit sil);
      int len, i, g;
      bit hs;
      len = (which == 0) ? 6 : 2;
      i = 0; g = 0;
      wr_addr_log.delete();
      wr_data_log.delete();
      @(posedge clk); #1;
      start = 1'b1; prog_len = 9'(len);
      @(posedge clk); #1;
      start = 1'b0;
      while (i < len && g < 500) begin
         prog_valid = (bp == 0) ? 1'b1 : (bp == 1) ? (g % 2 == 0) : ($urandom_range(1) == 1);
         prog_data  = (which == 0) ? prog_norm[i] : prog_loop[i];
         start      = sil && (i == 2);
         if (sil && i == 2) prog_len = 9'd3;
         hs = prog_valid && prog_ready;
         @(posedge clk); #1;
         if (hs) i++;
         g++;
      end
      prog_valid = 1'b0; start = 1'b0;
      chk("load_words_accepted", 32'(i), 32'(len));
      chk("run_entry_core_rst", 32'(core_rst), 32'd0);
      chk("last_write_we", 32'(imem_we), 32'd1);
      chk("last_write_addr", 32'(imem_addr), 32'(len - 1));
      @(posedge clk); #1;
      chk("write_count", 32'(wr_addr_log.size()), 32'(len));
      for (int k = 0; k < len && k < wr_addr_log.size(); k++) begin
         chk($sformatf("write_addr[%0d]", k), 32'(wr_addr_log[k]), 32'(k));
         chk($sformatf("write_data[%0d]", k), wr_data_log[k],
             (which == 0) ? prog_norm[k] : prog_loop[k]);
      end
   endtask

   task automatic run_checks(input logic [4:0] rq [$], input logic [31:0] vq [$], input int mode);
      int i, g;
      bit hs;
      i = 0; g = 0;
      while (!chk_ready && g < 300) begin
         @(posedge clk); #1;
         g++;
      end
      chk("chk_ready_seen", 32'(chk_ready), 32'd1);
      core_en_at_chk = core_en;
      g = 0;
      while (i < rq.size() && g < rq.size() * 6 + 50) begin
         chk_valid = (mode == 0) ? 1'b1 : ($urandom_range(1) == 1);
         chk_reg   = rq[i];
         chk_value = vq[i];
         chk_last  = (i == rq.size() - 1);
         hs = chk_valid && chk_ready;
         @(posedge clk); #1;
         if (hs) i++;
         g++;
      end
      chk_valid = 1'b0; chk_last = 1'b0;
      chk("check_stream_complete", 32'(i), 32'(rq.size()));
      chk("done_during_cmp", 32'(done), 32'd0);
      @(posedge clk); #1;
      chk("done_after_cmp", 32'(done), 32'd1);
   endtask

   task automatic check_result(input string nm, input int ef, input int efirst,
                               input bit epass, input bit etmo, input int ecyc);
      chk({nm, "_fail_count"}, 32'(fail_count), 32'(ef));
      chk({nm, "_first_fail"}, 32'(first_fail_reg), 32'(efirst));
      chk({nm, "_pass"}, 32'(pass), 32'(epass));
      chk({nm, "_timeout"}, 32'(timeout), 32'(etmo));
      chk({nm, "_cycles"}, 32'(cycles), 32'(ecyc));
      chk({nm, "_busy"}, 32'(busy), 32'd0);
      chk({nm, "_core_en_at_chk"}, 32'(core_en_at_chk), 32'd0);
      chk({nm, "_core_en_done"}, 32'(core_en), 32'd0);
   endtask

   logic [4:0]  rq [$];
   logic [31:0] vq [$];

   initial begin
      prog_norm[0] = 32'h20080005;  // addi $t0,$0,5
      prog_norm[1] = 32'h2009000A;  // addi $t1,$0,10
      prog_norm[2] = 32'h01095020;  // add  $t2,$t0,$t1
      prog_norm[3] = 32'h01285822;  // sub  $t3,$t1,$t0
      prog_norm[4] = 32'hAC0A0000;  // sw   $t2,0($0)
      prog_norm[5] = 32'h08000005;  // j    5 (self)
      prog_loop[0] = 32'h21080001;  // addi $t0,$t0,1
      prog_loop[1] = 32'h08000000;  // j    0

      ctab[0] = '{5'd8, 32'd5};  ctab[1] = '{5'd9, 32'd10};
      ctab[2] = '{5'd10, 32'd15}; ctab[3] = '{5'd11, 32'd5};
      ctab[4] = '{5'd8, 32'd5};  ctab[5] = '{5'd9, 32'd10};
      ctab[6] = '{5'd10, 32'd16}; ctab[7] = '{5'd11, 32'd6};
      ctab[8] = '{5'd8, 32'd10};
      // self-jump reached at RUN cycle 6, then STALL-1 more identical samples -> 9
      scen[0] = '{0, 0, 1'b0, 0, 4, 0, 0, 1'b1, 1'b0, 9};
      scen[1] = '{0, 0, 1'b0, 4, 4, 2, 10, 1'b0, 1'b0, 9};
      scen[2] = '{0, 1, 1'b1, 0, 4, 0, 0, 1'b1, 1'b0, 9};
      scen[3] = '{1, 0, 1'b0, 8, 1, 0, 0, 1'b0, 1'b1, MAXC};

      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_core_rst", 32'(core_rst), 32'd1);
      chk("rst_core_en", 32'(core_en), 32'd0);
      chk("rst_handshakes", 32'({prog_ready, chk_ready, imem_we}), 32'd0);
      chk("rst_flags", 32'({busy, done, pass, timeout}), 32'd0);
      chk("rst_counts", 32'({fail_count, first_fail_reg}), 32'd0);
      chk("rst_cycles", 32'(cycles), 32'd0);
      chk("rst_addr", 32'({rf_raddr, imem_addr}), 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      rst = 1'b1;

      for (int s = 0; s < 4; s++) begin
         load_prog(scen[s].prog, scen[s].bp, scen[s].sil);
         rq.delete(); vq.delete();
         for (int k = 0; k < scen[s].cn; k++) begin
            rq.push_back(ctab[scen[s].cfirst + k].r);
            vq.push_back(ctab[scen[s].cfirst + k].v);
         end
         run_checks(rq, vq, 0);
         check_result($sformatf("scen%0d", s), scen[s].exp_fail, scen[s].exp_first,
                      scen[s].exp_pass, scen[s].exp_tmo, scen[s].exp_cyc);
      end

      // reset in the middle of RUN
      load_prog(0, 0, 1'b0);
      chk("mid_run_core_en", 32'(core_en), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("mid_rst_core_rst", 32'(core_rst), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_core_en", 32'(core_en), 32'd0);
      chk("mid_rst_cycles", 32'(cycles), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // prog_len = 0 reruns the retained program without reloading
      @(posedge clk); #1;
      start = 1'b1; prog_len = 9'd0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("len0_core_en", 32'(core_en), 32'd1);
      chk("len0_prog_ready", 32'(prog_ready), 32'd0);
      chk("len0_core_rst", 32'(core_rst), 32'd0);
      rq.delete(); vq.delete();
      for (int k = 0; k < 4; k++) begin rq.push_back(ctab[k].r); vq.push_back(ctab[k].v); end
      run_checks(rq, vq, 0);
      check_result("len0", 0, 0, 1'b1, 1'b0, 9);

      // saturation of the mismatch counter
      load_prog(0, 0, 1'b0);
      rq.delete(); vq.delete();
      for (int k = 0; k < 300; k++) begin rq.push_back(5'd8); vq.push_back(32'd0); end
      run_checks(rq, vq, 0);
      check_result("saturate", 255, 8, 1'b0, 1'b0, 9);

      // randomized check streams against the program's known results
      for (int it = 0; it < 8; it++) begin
         int n, mism, first;
         n = $urandom_range(12, 1);
         mism = 0; first = 0;
         rq.delete(); vq.delete();
         for (int k = 0; k < n; k++) begin
            int r;
            logic [31:0] v;
            r = $urandom_range(31, 0);
            v = ref_val(r);
            if ($urandom_range(2, 0) == 0) begin
               v = v ^ (32'd1 << $urandom_range(31, 0));
               if (mism == 0) first = r;
               mism++;
            end
            rq.push_back(5'(r));
            vq.push_back(v);
         end
         load_prog(0, 2, 1'b0);
         run_checks(rq, vq, 1);
         check_result($sformatf("rand%0d", it), (mism > 255) ? 255 : mism, first,
                      mism == 0, 1'b0, 9);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_test_sequencer.md
# mips_test_sequencer

Synthesizable program loader and result checker for the single-cycle MIPS core. On `start` it streams a program into instruction memory while holding the core in reset, then releases the core and runs it until a halt (PC stuck on a jump-to-self) or a cycle timeout. It then freezes the core and compares a stream of expected register values against the register file, reporting pass/fail, mismatch count, and cycles used. It sits between an external host/stimulus stream and the core's `inst_mem` write port, reset input, clock enable, PC output, and register-file debug read port.

## Interface
- `XLEN`, 32: data/instruction word width.
- `IMEM_AW`, 8: instruction memory word-address width.
- `RUN_W`, 16: cycle counter width.
- `MAX_RUN_CYCLES`, 256: timeout limit, 1..2^RUN_W-1.
- `STALL_CYCLES`, 4: consecutive identical PC samples that count as halted, ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request, honoured only in IDLE or DONE.
- `prog_len` in IMEM_AW+1: program length in words, sampled on `start`.
- `prog_valid` in 1, `prog_ready` out 1, `prog_data` in XLEN: program word stream.
- `imem_we` out 1, `imem_addr` out IMEM_AW, `imem_wdata` out XLEN: instruction memory write port.
- `core_rst` out 1: active-high reset to the core.
- `core_en` out 1: clock enable to the core.
- `core_pc` in XLEN: core program counter.
- `rf_raddr` out 5, `rf_rdata` in XLEN: register-file debug read port; combinational read.
- `chk_valid` in 1, `chk_ready` out 1, `chk_reg` in 5, `chk_value` in XLEN, `chk_last` in 1: expected-value stream.
- `busy`, `done`, `pass`, `timeout` out 1 each: status flags.
- `fail_count` out 8: number of mismatches.
- `first_fail_reg` out 5: register index of the first mismatch.
- `cycles` out RUN_W: core cycles executed.

## Operation
- States:
  - IDLE: `core_rst`=1, `core_en`=0.
  - LOAD: `core_rst`=1, `prog_ready`=1.
  - RUN: `core_rst`=0, `core_en`=1.
  - CHK_REQ: `core_en`=0, `chk_ready`=1.
  - CHK_CMP: `core_en`=0.
  - DONE: `core_en`=0, `done`=1.
- On `start`:
  - Clear `fail_count`, `first_fail_reg`, `cycles`, `timeout`; zero the write address.
  - Go to LOAD, or directly to RUN if `prog_len`=0.
  - `start` in any other state is ignored.
- LOAD:
  - Each `prog_valid & prog_ready` writes `prog_data` at the current address, then increments the address.
  - After `prog_len` words, go to RUN. `prog_len` > 2^IMEM_AW wraps the address (later words overwrite earlier ones).
- RUN:
  - `cycles` increments every cycle.
  - A stall counter increments when `core_pc` equals the previous cycle's PC and clears otherwise.
  - Halt when the stall count reaches STALL_CYCLES-1 → CHK_REQ.
  - Otherwise, when `cycles` reaches MAX_RUN_CYCLES, set `timeout` → CHK_REQ. If both occur on the same cycle, halt wins and `timeout` stays 0.
- CHK_REQ:
  - On handshake, latch `chk_value` and `chk_last`; drive `rf_raddr`=`chk_reg` (registered) → CHK_CMP.
- CHK_CMP:
  - Compare `rf_rdata` with the latched value.
  - On mismatch: `fail_count` increments, saturating at 255; `first_fail_reg` is captured only if `fail_count` was 0.
  - If the latched last flag is set → DONE, else → CHK_REQ.
- DONE: `pass` = (`fail_count`==0 && !`timeout`). Holds until the next `start`.
- `busy` = state ∉ {IDLE, DONE}.

## Timing
- Reset values:
  - State IDLE, `core_rst`=1, `core_en`=0.
  - `prog_ready`, `chk_ready`, `imem_we`, `busy`, `done`, `pass`, `timeout` = 0.
  - `fail_count`, `first_fail_reg`, `cycles`, `rf_raddr`, `imem_addr`, `imem_wdata` = 0.
- Reset mid-operation returns to IDLE immediately and holds the core in reset. Memory contents are not cleared.
- Imem write latency: `imem_we`/`imem_addr`/`imem_wdata` are registered and assert the cycle after each handshake.
- RUN entry: `core_rst` falls on the first RUN cycle, which is the cycle after the last write is issued. `cycles`=1 at the end of that cycle.
- Freeze: `core_en` falls on the cycle the state leaves RUN. The register file is stable from then on.
- Check throughput: one register per 2 cycles minimum. `chk_ready` is low in CHK_CMP.
- `done` and `pass` assert the cycle after the final CHK_CMP.

## Structure
- Package `mips_tb_pkg`:
  - State enum `seq_state_t`.
  - `REG_AW`=5.
  - Default `XLEN`.
- Sub-module `run_monitor`: stall counter, cycle counter, halt/timeout decision.
- Parameters `RUN_W`, `MAX_RUN_CYCLES`, `STALL_CYCLES` pass through to `run_monitor`.

## Test plan
- Normal pass:
  - Stimulus: load 6 words (addi $t0=5, addi $t1=10, add $t2, sub $t3, sw, j self); check $t0=5, $t1=10, $t2=15, $t3=5 with `chk_last` on the 4th.
  - Required: `done`=1, `pass`=1, `fail_count`=0, `cycles` ≤ 10.
- Mismatch:
  - Stimulus: same program; expect $t2=16 and $t3=6.
  - Required: `fail_count`=2, `first_fail_reg`=10, `pass`=0.
- Timeout:
  - Stimulus: MAX_RUN_CYCLES=20; program loops, incrementing $t0 with no self-jump.
  - Required: `timeout`=1, `cycles`=20, `pass`=0, `core_en`=0 from then on.
- Backpressure:
  - Stimulus: `prog_valid` toggles 1/0 on alternate cycles.
  - Required: `imem_addr` 0..5 sequential, exactly 6 `imem_we` pulses, no duplicate writes.
- Reset mid-RUN:
  - Stimulus: assert `rst`=0 at cycle 3 of RUN.
  - Required: `core_rst`=1 and state IDLE asynchronously, `busy`=0; a subsequent `start` reruns correctly.
- Corner cases:
  - `prog_len`=0 goes straight to RUN.
  - `start` pulsed during LOAD is ignored.
  - `fail_count` saturates at 255 with 300 wrong checks.
